// File: rtl/movsum_pkg.sv
// movsum_pkg: shared definitions for the movsum_acc accumulator.
//   mode_e   - operating mode encoding (MODE_ACC / MODE_MOV)
//   wide_t   - 64-bit signed working type for the saturating adder
//   clog2    - ceiling log2 for elaboration-time sizing
//   sat_add  - a + b clamped to the signed range of a w-bit result
package movsum_pkg;

  typedef enum logic {
    MODE_ACC = 1'b0,
    MODE_MOV = 1'b1
  } mode_e;

  localparam int unsigned SAT_MAX_W = 64;

  typedef logic signed [SAT_MAX_W-1:0] wide_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Operands are sign-extended w-bit values; with w < 64 the 64-bit sum
  // cannot wrap, so plain signed compares find the overflow.
  function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                    input int unsigned w);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = a + b;
    hi  = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/movsum_ring.sv
// movsum_ring: DEPTH x IW sample history for the moving-sum window.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (entries and pointer to zero)
//   clr  - synchronous clear, same effect as rst, priority over we
//   we   - write din at the pointer and advance the pointer
//   din  - sample to store
//   dout - entry at the current pointer (oldest sample), combinational
module movsum_ring
  import movsum_pkg::*;
#(
  parameter int unsigned IW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 we,
  input  logic signed [IW-1:0] din,
  output logic signed [IW-1:0] dout
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic signed [IW-1:0] ring_q [DEPTH];
  logic signed [IW-1:0] ring_d [DEPTH];

  assign dout = ring_q[ptr_q];

  always_comb begin
    ring_d = ring_q;
    ptr_d  = ptr_q;
    if (clr) begin
      ring_d = '{default: '0};
      ptr_d  = '0;
    end else if (we) begin
      ring_d[ptr_q] = din;
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      ring_q <= '{default: '0};
    end else begin
      ptr_q  <= ptr_d;
      ring_q <= ring_d;
    end
  end

endmodule

// File: rtl/movsum_acc.sv
// movsum_acc: enabled signed accumulator with two modes.
//   mode=0: saturating running sum of accepted samples
//   mode=1: moving (boxcar) sum of the last DEPTH samples
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   en    - sample strobe; in is consumed when en=1
//   clr   - synchronous clear of all accumulation state, over en
//   mode  - 0 accumulate, 1 moving sum; a change acts as a clear
//   in    - signed IW-bit sample
//   y     - signed W-bit registered result
//   valid - y holds a complete result for the current mode
module movsum_acc
  import movsum_pkg::*;
#(
  parameter int unsigned IW    = 8,
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 mode,
  input  logic signed [IW-1:0] in,
  output logic signed [W-1:0]  y,
  output logic                 valid
);

  localparam int unsigned CW = clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("movsum_acc: DEPTH must be a power of two in 2..256");
  end
  if (W < IW + clog2(DEPTH)) begin : g_bad_width
    $error("movsum_acc: W must be at least IW + clog2(DEPTH)");
  end
  if (W >= SAT_MAX_W) begin : g_too_wide
    $error("movsum_acc: W must be below 64");
  end

  mode_e                mode_q;
  mode_e                mode_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic signed [W-1:0]  y_q;
  logic signed [W-1:0]  y_d;
  logic                 valid_q;
  logic                 valid_d;

  logic                 clear;
  logic                 ring_we;
  logic signed [IW-1:0] old;
  logic signed [W-1:0]  in_ext;
  logic signed [W-1:0]  old_ext;
  logic signed [W-1:0]  y_sat;
  logic signed [W-1:0]  y_mov;

  assign clear   = clr | (mode_e'(mode) != mode_q);
  assign ring_we = en & ~clear & (mode_q == MODE_MOV);
  assign in_ext  = W'(in);
  assign old_ext = W'(old);
  assign y_sat   = W'(sat_add(wide_t'(y_q), wide_t'(in_ext), W));
  // W >= IW + clog2(DEPTH) bounds the window sum, so this cannot wrap.
  assign y_mov   = y_q + in_ext - old_ext;

  movsum_ring #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .we   (ring_we),
    .din  (in),
    .dout (old)
  );

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    y_d     = y_q;
    valid_d = valid_q;
    if (clear) begin
      mode_d  = mode_e'(mode);
      count_d = '0;
      y_d     = '0;
      valid_d = 1'b0;
    end else if (en) begin
      if (mode_q == MODE_ACC) begin
        y_d     = y_sat;
        valid_d = 1'b1;
      end else begin
        y_d     = y_mov;
        if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
        valid_d = valid_q | (count_q == CW'(DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= mode_e'(mode);
      count_q <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_movsum_acc.sv
module tb_movsum_acc;

  logic clk;
  logic rst;
  logic en;
  logic clr;
  logic mode;
  logic signed [7:0]  in;
  logic signed [31:0] y32;
  logic               v32;
  logic signed [9:0]  y10;
  logic               v10;

  int n_tests;
  int n_fail;

  typedef struct {
    string            name;
    logic             rst;
    logic             en;
    logic             clr;
    logic             mode;
    logic signed [7:0] in;
    logic             sel;      // 0: default instance, 1: W=10 instance
    logic signed [31:0] exp_y;
    logic             exp_v;
  } vec_t;

  vec_t vecs[$];

  movsum_acc #(.IW(8), .W(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .in(in),
    .y(y32), .valid(v32)
  );

  movsum_acc #(.IW(8), .W(10), .DEPTH(4)) dut10 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .in(in),
    .y(y10), .valid(v10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic e,
                     input logic c, input logic m, input int smp,
                     input logic sel, input int ey, input logic ev);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.clr = c; v.mode = m;
    v.in = 8'(smp); v.sel = sel; v.exp_y = 32'(ey); v.exp_v = ev;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic e, input logic c,
                      input logic m, input int smp);
    @(negedge clk);
    rst = r; en = e; clr = c; mode = m; in = 8'(smp);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic sel,
                       input int ey, input logic ev);
    logic signed [31:0] ay;
    logic               av;
    if (sel) begin
      ay = 32'(y10);
      av = v10;
    end else begin
      ay = y32;
      av = v32;
    end
    n_tests++;
    if (ay !== 32'(ey) || av !== ev) begin
      n_fail++;
      $display("FAIL %s: y=%0d valid=%0b, expected y=%0d valid=%0b",
               name, ay, av, ey, ev);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0; in = '0;

    // accumulate, default width
    add("acc_rst0", 1, 0, 0, 0, 0,   0, 0, 0);
    add("acc_rst1", 1, 1, 0, 0, 7,   0, 0, 0);
    add("acc_s5",   0, 1, 0, 0, 5,   0, 5, 1);
    add("acc_sm3",  0, 1, 0, 0, -3,  0, 2, 1);
    add("acc_s10",  0, 1, 0, 0, 10,  0, 12, 1);
    add("acc_idle", 0, 0, 0, 0, 99,  0, 12, 1);
    // W=10 positive clamp, then walk back down
    add("sat_rst",  1, 0, 0, 0, 0,   1, 0, 0);
    add("sat_p1",   0, 1, 0, 0, 127, 1, 127, 1);
    add("sat_p2",   0, 1, 0, 0, 127, 1, 254, 1);
    add("sat_p3",   0, 1, 0, 0, 127, 1, 381, 1);
    add("sat_p4",   0, 1, 0, 0, 127, 1, 508, 1);
    add("sat_p5",   0, 1, 0, 0, 127, 1, 511, 1);
    add("sat_n1",   0, 1, 0, 0, -128, 1, 383, 1);
    add("sat_n2",   0, 1, 0, 0, -128, 1, 255, 1);
    add("sat_n3",   0, 1, 0, 0, -128, 1, 127, 1);
    add("sat_n4",   0, 1, 0, 0, -128, 1, -1, 1);
    add("sat_n5",   0, 1, 0, 0, -128, 1, -129, 1);
    // W=10 negative clamp
    add("neg_rst",  1, 0, 0, 0, 0,   1, 0, 0);
    add("neg_1",    0, 1, 0, 0, -128, 1, -128, 1);
    add("neg_2",    0, 1, 0, 0, -128, 1, -256, 1);
    add("neg_3",    0, 1, 0, 0, -128, 1, -384, 1);
    add("neg_4",    0, 1, 0, 0, -128, 1, -512, 1);
    add("neg_5",    0, 1, 0, 0, -128, 1, -512, 1);
    add("neg_6",    0, 1, 0, 0, -128, 1, -512, 1);
    add("neg_7",    0, 1, 0, 0, -128, 1, -512, 1);
    add("neg_8",    0, 1, 0, 0, -128, 1, -512, 1);
    // moving sum, pointer wrap
    add("mov_rst",  1, 0, 0, 1, 0,   0, 0, 0);
    add("mov_1",    0, 1, 0, 1, 1,   0, 1, 0);
    add("mov_2",    0, 1, 0, 1, 2,   0, 3, 0);
    add("mov_3",    0, 1, 0, 1, 3,   0, 6, 0);
    add("mov_4",    0, 1, 0, 1, 4,   0, 10, 1);
    add("mov_5",    0, 1, 0, 1, 5,   0, 14, 1);
    add("mov_6",    0, 1, 0, 1, 6,   0, 18, 1);
    // moving sum extremes and hold
    add("mne_rst",  1, 0, 0, 1, 0,   0, 0, 0);
    add("mne_1",    0, 1, 0, 1, -128, 0, -128, 0);
    add("mne_2",    0, 1, 0, 1, -128, 0, -256, 0);
    add("mne_3",    0, 1, 0, 1, -128, 0, -384, 0);
    add("mne_4",    0, 1, 0, 1, -128, 0, -512, 1);
    add("mne_h1",   0, 0, 0, 1, 77,  0, -512, 1);
    add("mne_h2",   0, 0, 0, 1, 77,  0, -512, 1);
    add("mne_h3",   0, 0, 0, 1, 77,  0, -512, 1);
    add("mne_127",  0, 1, 0, 1, 127, 0, -257, 1);
    // mode switch mid-window discards the sample
    add("sw_rst",   1, 0, 0, 1, 0,   0, 0, 0);
    add("sw_1",     0, 1, 0, 1, 1,   0, 1, 0);
    add("sw_2",     0, 1, 0, 1, 2,   0, 3, 0);
    add("sw_3",     0, 1, 0, 1, 3,   0, 6, 0);
    add("sw_tog",   0, 1, 0, 0, 9,   0, 0, 0);
    add("sw_acc4",  0, 1, 0, 0, 4,   0, 4, 1);
    // priority rst > clr > en
    add("pri_rstclr", 1, 1, 1, 0, 50, 0, 0, 0);
    add("pri_clr",    0, 1, 1, 0, 50, 0, 0, 0);
    add("pri_after",  0, 1, 0, 0, 50, 0, 50, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].in);
      check(vecs[i].name, vecs[i].sel, vecs[i].exp_y, vecs[i].exp_v);
    end

    // clr mid-window must zero the ring and pointer: refill sums from scratch
    step(1, 0, 0, 1, 0);
    step(0, 1, 0, 1, 7);  check("rc_7a", 0, 7, 0);
    step(0, 1, 0, 1, 7);  check("rc_7b", 0, 14, 0);
    step(0, 1, 0, 1, 7);  check("rc_7c", 0, 21, 0);
    step(0, 1, 1, 1, 7);  check("rc_clr", 0, 0, 0);
    step(0, 1, 0, 1, 1);  check("rc_1", 0, 1, 0);
    step(0, 1, 0, 1, 2);  check("rc_2", 0, 3, 0);
    step(0, 1, 0, 1, 3);  check("rc_3", 0, 6, 0);
    step(0, 1, 0, 1, 4);  check("rc_4", 0, 10, 1);
    step(0, 1, 0, 1, -20); check("rc_m20", 0, -11, 1);

    // switch from accumulate into moving sum: cleared, then window restarts
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 100); check("am_acc", 0, 100, 1);
    step(0, 1, 0, 1, 30);  check("am_tog", 0, 0, 0);
    step(0, 1, 0, 1, 30);  check("am_m1", 0, 30, 0);
    step(0, 0, 0, 1, 30);  check("am_idle", 0, 30, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/movsum_acc.md
Name: movsum_acc

Overview:
Parametrised successor to the single-channel enabled accumulator. It takes a signed IW-bit sample on each enabled clock and produces a signed W-bit result in one of two modes:
- saturating running accumulation;
- moving (boxcar) sum of the last DEPTH samples.

It sits in the datapath between the sample source and downstream arithmetic. Result and valid flag are registered.

Parameters:
IW, 8, signed input sample width
W, 32, signed output width; must satisfy W >= IW + clog2(DEPTH) (elaboration-time check, $error otherwise)
DEPTH, 4, moving-sum window length; power of two, 2..256

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  sample strobe; in is consumed on a rising clk edge when en=1
clr  in  1  synchronous clear of all accumulation state; priority over en
mode  in  1  0 = saturating accumulate, 1 = moving sum over DEPTH samples
in  in  IW  signed input sample
y  out  W  signed registered result
valid  out  1  y holds a complete result for the current mode

Behaviour:
- Reset (rst=1 at an edge):
  - y=0, valid=0.
  - Sample count=0, ring write pointer=0, all ring entries=0.
  - mode_q=mode.
  - rst has priority over every other input.
- Clear condition: clr=1, or mode != mode_q. On that edge:
  - y=0, valid=0, count=0, pointer=0, ring entries zeroed, mode_q<=mode.
  - Any sample presented that cycle is discarded, even with en=1.
- Idle: en=0 and no clear -> all state holds; y and valid unchanged.
- Latency: a sample accepted at edge k is reflected in y and valid after edge k (visible in cycle k+1).
- Mode 0 (accumulate):
  - y <= sat(y + sext(in)), with the sum computed at W+1 bits.
  - Clamp to [-2^(W-1), 2^(W-1)-1].
  - valid <= 1 after the first accepted sample.
  - The ring buffer is not written.
- Mode 1 (moving sum):
  - old = ring[ptr].
  - ring[ptr] <= in.
  - ptr <= ptr+1 mod DEPTH (wrap DEPTH-1 -> 0).
  - y <= y + sext(in) - sext(old).
  - No saturation needed, guaranteed by the W constraint.
  - count saturates at DEPTH.
  - valid <= 1 on the edge where count reaches DEPTH, and stays 1 until reset or clear.
  - Before the window fills, y is the partial sum of the samples so far (ring starts zeroed).
- Simultaneous events:
  - rst > clear (clr or mode change) > en.
  - en held high for consecutive cycles accepts one sample per cycle, with no bubbles.
- Arithmetic:
  - All values are two's complement.
  - in is sign-extended to W.
  - old is sign-extended to W.

Decomposition:
- Package movsum_pkg:
  - MODE_ACC=1'b0, MODE_MOV=1'b1.
  - clog2 function.
  - Saturation helper function sat_add(a,b) parameterised by W.
- Sub-module movsum_ring: DEPTH x IW register array with write pointer.
  - Ports: clk, rst, clr, we, din, dout(old).
  - dout is combinational read at ptr.
  - Pointer wrap is handled internally.
- Top level: mode tracking, counter, adder/saturator, output registers.

Test Plan:
- Defaults, mode=0: rst 2 cycles, then samples 5,-3,10 with en=1 -> y=5,2,12; valid=1 from the first sample; y=0 and valid=0 during reset.
- W=10, mode=0: five samples of 127 -> y=127,254,381,508,511 (saturated). Then five samples of -128 -> 383,255,127,-1,-129. Check the negative clamp separately with eight samples of -128 from 0 -> -512 held.
- Defaults, mode=1, DEPTH=4: samples 1,2,3,4,5,6 -> y=1,3,6,10,14,18; valid=0,0,0,1,1,1. Pointer wraps after the 4th sample.
- mode=1: samples -128 x4 -> y=-512, valid=1. Then en=0 for 3 cycles -> y=-512 held. Then samples 127 -> y=-257.
- Clear/mode switch: mid-window (y=6, count=3), toggle mode to 0 with en=1 and in=9 -> next cycle y=0, valid=0, sample discarded. Then sample 4 -> y=4, valid=1.
- Priority: assert rst and clr together with en=1 and in=50 at an edge -> y=0, valid=0. Then clr=1 alone with en=1 -> y stays 0.
